// File: rtl/uart_bus_responder.sv
// Memory-mapped UART responder: bus byte writes go out on txd, received bytes are read back over the bus.
// Latency: a write reaches txd about 4 clk after wrn rises; a received byte is in RBR about 2 clk after mid-stop.
// Backpressure: one THR slot; a write while tbre=0 is dropped; an unread RBR is overwritten and rx_overrun is set.
//
// Ports:
//   clk, rst            sole clock; asynchronous active-high reset
//   data_in, wrn        bus write byte and active-low write strobe (THR load on strobe release)
//   data_out, data_oe   RBR value and its bus-drive enable, active while rdn is low
//   rdn                 active-low read strobe; releasing it clears data_ready
//   data_ready          RBR holds an unread byte
//   tbre, tsre          THR empty / shift register empty (line idle)
//   rxd, txd            serial lines, idle high, 8N1, CLK_DIV clk per bit
//   rx_overrun          sticky: an unread byte was overwritten
//   frame_err           sticky: a frame ended with a low stop bit
module uart_bus_responder #(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic       rdn,
  input  logic       wrn,
  output logic       data_ready,
  output logic       tbre,
  output logic       tsre,
  input  logic       rxd,
  output logic       txd,
  output logic       rx_overrun,
  output logic       frame_err
);

  localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'((CLK_DIV / 2) - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Synchronizer chains; stage 3 is the previous value of the synchronized copy, used for edges.
  logic rdn_s1_q, rdn_s2_q, rdn_s3_q;
  logic wrn_s1_q, wrn_s2_q, wrn_s3_q;
  logic rxd_s1_q, rxd_s2_q, rxd_s3_q;
  logic [7:0] din_s1_q;
  logic [7:0] din_hold_q, din_hold_d;

  // Transmit side
  tx_state_t   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  thr_q, thr_d;
  logic        tbre_q, tbre_d;
  logic        tsre_q, tsre_d;
  logic        txd_q, txd_d;

  // Receive side
  rx_state_t   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_wait_q, rx_wait_d;
  logic [7:0]  rbr_q, rbr_d;
  logic        data_ready_q, data_ready_d;
  logic        rx_overrun_q, rx_overrun_d;
  logic        frame_err_q, frame_err_d;

  logic wr_rise;
  logic rd_rise;
  logic rx_fall;

  assign wr_rise = wrn_s2_q & ~wrn_s3_q;
  assign rd_rise = rdn_s2_q & ~rdn_s3_q;
  assign rx_fall = rxd_s3_q & ~rxd_s2_q;

  // Bus data is only guaranteed while wrn is low, so keep the last first-stage sample taken
  // while the first-stage wrn copy was low; by the time the synchronized edge arrives this
  // holds the byte that went with the strobe.
  always_comb begin
    din_hold_d = wrn_s1_q ? din_hold_q : din_s1_q;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    thr_d      = thr_q;
    tbre_d     = tbre_q;
    tsre_d     = tsre_q;
    txd_d      = txd_q;

    // The write and the THR->shift transfer need opposite tbre values, so they never collide.
    if (wr_rise && tbre_q) begin
      thr_d  = din_hold_q;
      tbre_d = 1'b0;
    end

    case (tx_state_q)
      TX_IDLE: begin
        if (!tbre_q) begin
          tx_shift_d = thr_q;
          tbre_d     = 1'b1;
          tsre_d     = 1'b0;
          txd_d      = 1'b0;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            // The bit on the line is shift[0]; shift right and present the next one.
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_cnt_d = '0;
          if (!tbre_q) begin
            // Queued byte: start the next frame with no idle gap.
            tx_shift_d = thr_q;
            tbre_d     = 1'b1;
            txd_d      = 1'b0;
            tx_state_d = TX_START;
          end else begin
            tsre_d     = 1'b1;
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_wait_d    = rx_wait_q;
    rbr_d        = rbr_q;
    data_ready_d = data_ready_q;
    rx_overrun_d = rx_overrun_q;
    frame_err_d  = frame_err_q;

    if (rd_rise) begin
      data_ready_d = 1'b0;
    end

    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          // Line back high at mid-start means a glitch, not a frame.
          rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == DIV_M1) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_wait_q) begin
          // After a framing error, hold off until the line returns high so a
          // break is not mistaken for a new start bit.
          if (rxd_s2_q) begin
            rx_wait_d  = 1'b0;
            rx_state_d = RX_IDLE;
          end
        end else if (rx_cnt_q == DIV_M1) begin
          rx_cnt_d = '0;
          if (rxd_s2_q) begin
            rbr_d        = rx_shift_q;
            data_ready_d = 1'b1;
            // A read completing in the same cycle consumed the old byte: no overrun.
            if (data_ready_q && !rd_rise) begin
              rx_overrun_d = 1'b1;
            end
            rx_state_d = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            rx_wait_d   = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdn_s1_q     <= 1'b1;
      rdn_s2_q     <= 1'b1;
      rdn_s3_q     <= 1'b1;
      wrn_s1_q     <= 1'b1;
      wrn_s2_q     <= 1'b1;
      wrn_s3_q     <= 1'b1;
      rxd_s1_q     <= 1'b1;
      rxd_s2_q     <= 1'b1;
      rxd_s3_q     <= 1'b1;
      din_s1_q     <= '0;
      din_hold_q   <= '0;
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      thr_q        <= '0;
      tbre_q       <= 1'b1;
      tsre_q       <= 1'b1;
      txd_q        <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_wait_q    <= 1'b0;
      rbr_q        <= '0;
      data_ready_q <= 1'b0;
      rx_overrun_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rdn_s1_q     <= rdn;
      rdn_s2_q     <= rdn_s1_q;
      rdn_s3_q     <= rdn_s2_q;
      wrn_s1_q     <= wrn;
      wrn_s2_q     <= wrn_s1_q;
      wrn_s3_q     <= wrn_s2_q;
      rxd_s1_q     <= rxd;
      rxd_s2_q     <= rxd_s1_q;
      rxd_s3_q     <= rxd_s2_q;
      din_s1_q     <= data_in;
      din_hold_q   <= din_hold_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      thr_q        <= thr_d;
      tbre_q       <= tbre_d;
      tsre_q       <= tsre_d;
      txd_q        <= txd_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_wait_q    <= rx_wait_d;
      rbr_q        <= rbr_d;
      data_ready_q <= data_ready_d;
      rx_overrun_q <= rx_overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Bus read path follows the synchronized strobe; data_out is parked at zero when not driving.
  assign data_oe    = ~rdn_s2_q;
  assign data_out   = rdn_s2_q ? 8'h00 : rbr_q;
  assign data_ready = data_ready_q;
  assign tbre       = tbre_q;
  assign tsre       = tsre_q;
  assign txd        = txd_q;
  assign rx_overrun = rx_overrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_bus_responder.sv
module tb_uart_bus_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;
  logic       rdn;
  logic       wrn;
  logic       data_ready;
  logic       tbre;
  logic       tsre;
  logic       rxd;
  logic       txd;
  logic       rx_overrun;
  logic       frame_err;

  int total = 0;
  int bad   = 0;

  uart_bus_responder #(.CLK_DIV(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_oe    (data_oe),
    .rdn        (rdn),
    .wrn        (wrn),
    .data_ready (data_ready),
    .tbre       (tbre),
    .tsre       (tsre),
    .rxd        (rxd),
    .txd        (txd),
    .rx_overrun (rx_overrun),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_write(input logic [7:0] d);
    @(posedge clk); #1;
    data_in = d;
    wrn = 1'b0;
    repeat (3) @(posedge clk);
    #1 wrn = 1'b1;
  endtask

  task automatic do_read(output logic [7:0] d, output logic oe);
    @(posedge clk); #1;
    rdn = 1'b0;
    repeat (4) @(negedge clk);
    d  = data_out;
    oe = data_oe;
    @(posedge clk); #1;
    rdn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      rxd = f[i];
      repeat (7) @(posedge clk);
    end
    @(posedge clk); #1;
    rxd = 1'b1;
  endtask

  task automatic wait_txd_low(input string nm, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      n++;
      if (txd === 1'b0) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_start: txd=%b after %0d clk, required a start bit (0)", nm, txd, n);
    end
  endtask

  // Called at the first negedge where txd is low; checks every cycle of all 10 bit cells.
  task automatic check_frame(input logic [7:0] d, input string nm);
    logic [9:0] e_bits;
    logic       ok;
    logic       got_v;
    e_bits = {1'b1, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      ok    = 1'b1;
      got_v = e_bits[b];
      for (int c = 0; c < 8; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (txd !== e_bits[b]) begin
          ok    = 1'b0;
          got_v = txd;
        end
      end
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL %s_bit%0d: txd=%b, required %b for 8 clk", nm, b, got_v, e_bits[b]);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({txd, tbre, tsre, data_ready, data_oe, rx_overrun, frame_err} !== 7'b1110000) begin
      bad++;
      $display("FAIL reset_flags: {txd,tbre,tsre,dr,oe,ovr,ferr}=%b required 1110000",
               {txd, tbre, tsre, data_ready, data_oe, rx_overrun, frame_err});
    end
    total++;
    if (data_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_data_out: got %h required 00", data_out);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if ({txd, tbre, tsre, data_ready} !== 4'b1110) begin
      bad++;
      $display("FAIL idle_after_reset: {txd,tbre,tsre,dr}=%b required 1110", {txd, tbre, tsre, data_ready});
    end
  endtask

  task automatic test_tx_single;
    bit saw0;
    bit done;
    int cyc;
    do_write(8'hA5);
    saw0 = 1'b0;
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (tbre === 1'b0) saw0 = 1'b1;
      if (txd === 1'b0) done = 1'b1;
    end
    total++;
    if (!(saw0 && done && tbre === 1'b1 && cyc <= 5)) begin
      bad++;
      $display("FAIL tbre_pulse: saw_low=%0d tbre=%b start_at=%0d clk, required 1->0->1 within 5 clk",
               saw0, tbre, cyc);
    end
    total++;
    if (tsre !== 1'b0) begin
      bad++;
      $display("FAIL tsre_busy: got %b required 0", tsre);
    end
    if (done) begin
      check_frame(8'hA5, "a5");
      @(negedge clk);
      total++;
      if ({tsre, tbre, txd} !== 3'b111) begin
        bad++;
        $display("FAIL a5_done: {tsre,tbre,txd}=%b required 111", {tsre, tbre, txd});
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    bit idle_ok;
    do_write(8'h55);
    wait_txd_low("b2b", ok);
    if (ok) begin
      fork
        begin
          check_frame(8'h55, "b2b_55");
          @(negedge clk);
          check_frame(8'h0F, "b2b_0f");
        end
        begin
          do_write(8'h0F);
          repeat (3) @(posedge clk);
          @(negedge clk);
          total++;
          if (tbre !== 1'b0) begin
            bad++;
            $display("FAIL thr_loaded: tbre=%b required 0", tbre);
          end
          do_write(8'hFF);
          repeat (4) @(negedge clk);
          total++;
          if (tbre !== 1'b0) begin
            bad++;
            $display("FAIL dropped_write_tbre: tbre=%b required 0", tbre);
          end
        end
      join
      @(negedge clk);
      idle_ok = (tsre === 1'b1) && (tbre === 1'b1);
      for (int i = 0; i < 30; i++) begin
        if (txd !== 1'b1) idle_ok = 1'b0;
        @(negedge clk);
      end
      total++;
      if (!idle_ok) begin
        bad++;
        $display("FAIL no_third_frame: tsre=%b tbre=%b txd=%b, required 1 1 1 with line idle", tsre, tbre, txd);
      end
    end
  endtask

  task automatic test_rx_read;
    logic [7:0] d;
    logic       oe;
    send_byte(8'h3C, 1'b1);
    @(negedge clk);
    total++;
    if (data_ready !== 1'b1) begin
      bad++;
      $display("FAIL rx3c_ready: got %b required 1", data_ready);
    end
    do_read(d, oe);
    total++;
    if ({oe, d} !== {1'b1, 8'h3C}) begin
      bad++;
      $display("FAIL rx3c_read: oe=%b data=%h required oe=1 data=3c", oe, d);
    end
    @(negedge clk);
    total++;
    if ({data_ready, data_oe, rx_overrun} !== 3'b000) begin
      bad++;
      $display("FAIL rx3c_after_read: {dr,oe,ovr}=%b required 000", {data_ready, data_oe, rx_overrun});
    end
  endtask

  task automatic test_overrun_glitch;
    logic [7:0] d;
    logic       oe;
    bit         stay;
    send_byte(8'h11, 1'b1);
    @(negedge clk);
    total++;
    if ({data_ready, rx_overrun} !== 2'b10) begin
      bad++;
      $display("FAIL rx11: {dr,ovr}=%b required 10", {data_ready, rx_overrun});
    end
    send_byte(8'h22, 1'b1);
    @(negedge clk);
    total++;
    if ({data_ready, rx_overrun} !== 2'b11) begin
      bad++;
      $display("FAIL overrun: {dr,ovr}=%b required 11", {data_ready, rx_overrun});
    end
    do_read(d, oe);
    total++;
    if (d !== 8'h22) begin
      bad++;
      $display("FAIL overrun_rbr: got %h required 22", d);
    end
    // 2-clk low glitch on rxd
    @(posedge clk); #1 rxd = 1'b0;
    repeat (2) @(posedge clk);
    #1 rxd = 1'b1;
    stay = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (data_ready !== 1'b0 || frame_err !== 1'b0) stay = 1'b0;
    end
    total++;
    if (!stay) begin
      bad++;
      $display("FAIL glitch: dr=%b ferr=%b, required 0 0 throughout", data_ready, frame_err);
    end
  endtask

  task automatic test_frame_err;
    logic [7:0] d;
    logic       oe;
    send_byte(8'h7E, 1'b0);
    repeat (3) @(negedge clk);
    total++;
    if ({frame_err, data_ready, rx_overrun} !== 3'b101) begin
      bad++;
      $display("FAIL frame_err: {ferr,dr,ovr}=%b required 101", {frame_err, data_ready, rx_overrun});
    end
    do_read(d, oe);
    total++;
    if (d !== 8'h22) begin
      bad++;
      $display("FAIL frame_err_rbr: got %h required 22", d);
    end
  endtask

  task automatic test_concurrent;
    logic [7:0] d;
    logic       oe;
    bit         ok;
    fork
      begin
        do_write(8'h5A);
        wait_txd_low("conc", ok);
        if (ok) check_frame(8'h5A, "conc_5a");
      end
      begin
        send_byte(8'h81, 1'b1);
      end
    join
    repeat (2) @(negedge clk);
    total++;
    if (data_ready !== 1'b1) begin
      bad++;
      $display("FAIL conc_ready: got %b required 1", data_ready);
    end
    do_read(d, oe);
    total++;
    if (d !== 8'h81) begin
      bad++;
      $display("FAIL conc_rbr: got %h required 81", d);
    end
  endtask

  task automatic test_reset_mid_tx;
    bit ok;
    bit idle_ok;
    do_write(8'hC3);
    wait_txd_low("rst", ok);
    if (ok) begin
      repeat (36) @(negedge clk);
      total++;
      if (tsre !== 1'b0) begin
        bad++;
        $display("FAIL mid_tx_busy: tsre=%b required 0", tsre);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if ({txd, tsre, tbre, rx_overrun, frame_err} !== 5'b11100) begin
        bad++;
        $display("FAIL async_reset: {txd,tsre,tbre,ovr,ferr}=%b required 11100",
                 {txd, tsre, tbre, rx_overrun, frame_err});
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      idle_ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (txd !== 1'b1 || tsre !== 1'b1) idle_ok = 1'b0;
      end
      total++;
      if (!idle_ok) begin
        bad++;
        $display("FAIL no_resume: txd=%b tsre=%b required 1 1 while idle", txd, tsre);
      end
      do_write(8'h96);
      wait_txd_low("post_rst", ok);
      if (ok) check_frame(8'h96, "post_rst_96");
    end
  endtask

  initial begin
    rst     = 1'b1;
    data_in = 8'h00;
    rdn     = 1'b1;
    wrn     = 1'b1;
    rxd     = 1'b1;
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_rx_read();
    test_overrun_glitch();
    test_frame_err();
    test_concurrent();
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
